register_16bit_unloader: RTL



---
 rtl/register_16bit_unloader.sv | 100 ++++++++++
 1 files changed

// File: rtl/register_16bit_unloader.sv
// register_16bit_unloader: captures a 16-bit word and base address, then
// presents the word as two bytes with a valid/ready handshake. The first byte
// goes to the base address and the second byte to base+1 or base-1. A
// one-cycle done pulse follows the second accepted byte.
module register_16bit_unloader #(
  parameter bit HIGH_FIRST = 1'b1,  // 1: bits [15:8] go out first
  parameter bit ADDR_DIR   = 1'b1   // 1: second address is base-1 (descending push)
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] valuein,
  input  logic [15:0] addrbase,
  input  logic        byteready,
  output logic [7:0]  byteout,
  output logic [15:0] addrout,
  output logic        bytevalid,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FIRST  = 2'd1,
    S_SECOND = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_word;
  logic [15:0] r_base;
  logic [7:0]  r_byteout;
  logic [15:0] r_addrout;
  logic        r_done;

  logic        w_accept;
  logic        w_xfer;
  logic [7:0]  w_load_byte;
  logic [7:0]  w_second_byte;
  logic [15:0] w_second_addr;

  // The first byte is taken straight from valuein so it is on the bus in the
  // cycle right after start is accepted. The second byte comes from the
  // captured copy.
  assign w_load_byte   = HIGH_FIRST ? valuein[15:8] : valuein[7:0];
  assign w_second_byte = HIGH_FIRST ? r_word[7:0]   : r_word[15:8];
  assign w_second_addr = ADDR_DIR ? (r_base - 16'd1) : (r_base + 16'd1);

  assign w_accept = (r_state == S_IDLE) && start;
  assign w_xfer   = (r_state != S_IDLE) && byteready;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic. Leaving a byte state requires a handshake.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (start)     w_state_nxt = S_FIRST;
      S_FIRST:  if (byteready) w_state_nxt = S_SECOND;
      S_SECOND: if (byteready) w_state_nxt = S_IDLE;
      default:                 w_state_nxt = S_IDLE;
    endcase
  end

  // Capture the word and base, and update the byte and address outputs only
  // on accept or on a transfer. This keeps the outputs stable while stalled.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_word    <= '0;
      r_base    <= '0;
      r_byteout <= '0;
      r_addrout <= '0;
    end else if (w_accept) begin
      r_word    <= valuein;
      r_base    <= addrbase;
      r_byteout <= w_load_byte;
      r_addrout <= addrbase;
    end else if (w_xfer && (r_state == S_FIRST)) begin
      r_byteout <= w_second_byte;
      r_addrout <= w_second_addr;
    end
  end

  // Pulse done for one cycle after the second byte is accepted.
  always_ff @(posedge clock) begin
    if (reset) r_done <= 1'b0;
    else       r_done <= w_xfer && (r_state == S_SECOND);
  end

  assign byteout   = r_byteout;
  assign addrout   = r_addrout;
  assign bytevalid = (r_state != S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;

endmodule
